// File: rtl/time_step_scheduler_pkg.sv
// Shared time format and scheduler state encoding.
package time_step_scheduler_pkg;

  localparam int TIME_WIDTH = 32;

  // Emulated time value, unsigned.
  typedef logic [TIME_WIDTH-1:0] time_fmt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ADVANCE,
    ST_DONE,
    ST_ERROR
  } sched_state_t;

endpackage

// File: rtl/time_step_scheduler_min_tree.sv
// Combinational minimum of N proposed times plus the mask of entries tied at it.
module time_min_tree
  import time_step_scheduler_pkg::*;
#(
  parameter int N = 4
) (
  input  time_fmt_t [N-1:0] times_i,
  output time_fmt_t         min_o,
  output logic [N-1:0]      tie_o
);

  time_fmt_t m;

  // Linear scan for the minimum, then flag every entry equal to it.
  always_comb begin
    m = times_i[0];
    for (int i = 1; i < N; i++) begin
      if (times_i[i] < m) m = times_i[i];
    end
    tie_o = '0;
    for (int i = 0; i < N; i++) begin
      tie_o[i] = (times_i[i] == m);
    end
  end

  assign min_o = m;

endmodule

// File: rtl/time_step_scheduler.sv
// Global timebase run controller: collects N proposals, advances time to the
// earliest one, grants all tied requesters, repeats until budget/stop/abort/error.
module time_step_scheduler
  import time_step_scheduler_pkg::*;
#(
  parameter int N           = 4,
  parameter int BUDGET_BITS = 16,
  parameter int MAX_WAIT    = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [BUDGET_BITS-1:0] step_budget_i,
  input  time_fmt_t              stop_time_i,
  input  logic [N-1:0]           req_valid_i,
  input  time_fmt_t [N-1:0]      req_time_i,
  output logic [N-1:0]           req_ready_o,
  output logic [N-1:0]           step_grant_o,
  output time_fmt_t              time_curr_o,
  output logic                   time_valid_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [BUDGET_BITS-1:0] steps_done_o,
  output logic                   timeout_err_o,
  output logic                   order_err_o
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  sched_state_t           state_q, state_d;
  logic [WW-1:0]          wait_q, wait_d;
  time_fmt_t              cand_time_q, cand_time_d;
  logic [N-1:0]           cand_mask_q, cand_mask_d;
  logic [N-1:0]           ready_q, ready_d;
  logic [N-1:0]           grant_q, grant_d;
  time_fmt_t              time_q, time_d;
  logic                   tvalid_q, tvalid_d;
  logic                   done_q, done_d;
  logic [BUDGET_BITS-1:0] steps_q, steps_d;
  logic                   terr_q, terr_d;
  logic                   oerr_q, oerr_d;

  time_fmt_t              min_time;
  logic [N-1:0]           tie_mask;
  logic [BUDGET_BITS-1:0] steps_inc;

  time_min_tree #(.N(N)) u_min (
    .times_i (req_time_i),
    .min_o   (min_time),
    .tie_o   (tie_mask)
  );

  assign steps_inc = steps_q + BUDGET_BITS'(1);

  // Next-state and output-register logic; abort overrides everything at the end.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    cand_time_d = cand_time_q;
    cand_mask_d = cand_mask_q;
    ready_d     = '0;
    grant_d     = grant_q;
    time_d      = time_q;
    tvalid_d    = 1'b0;
    done_d      = done_q;
    steps_d     = steps_q;
    terr_d      = terr_q;
    oerr_d      = oerr_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          state_d = ST_COLLECT;
          done_d  = 1'b0;
          terr_d  = 1'b0;
          oerr_d  = 1'b0;
          steps_d = '0;
          wait_d  = '0;
        end
      end
      ST_COLLECT: begin
        if (&req_valid_i) begin
          cand_time_d = min_time;
          cand_mask_d = tie_mask;
          wait_d      = '0;
          // Ready is registered here so it is high during ADVANCE; a backwards
          // minimum is known now already, so such a round consumes nothing.
          ready_d     = (min_time >= time_q) ? tie_mask : '0;
          state_d     = ST_ADVANCE;
        end else begin
          wait_d = wait_q + WW'(1);
          if (wait_q == WAIT_LAST) begin
            terr_d  = 1'b1;
            state_d = ST_ERROR;
          end
        end
      end
      ST_ADVANCE: begin
        if (cand_time_q < time_q) begin
          oerr_d  = 1'b1;
          state_d = ST_ERROR;
        end else begin
          time_d   = cand_time_q;
          grant_d  = cand_mask_q;
          tvalid_d = 1'b1;
          steps_d  = steps_inc;
          if (cand_time_q >= stop_time_i ||
              (step_budget_i != '0 && steps_inc == step_budget_i)) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_i) begin
      state_d  = ST_IDLE;
      wait_d   = wait_q;
      ready_d  = '0;
      grant_d  = grant_q;
      time_d   = time_q;
      tvalid_d = 1'b0;
      done_d   = done_q;
      steps_d  = steps_q;
      terr_d   = terr_q;
      oerr_d   = oerr_q;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      cand_time_q <= '0;
      cand_mask_q <= '0;
      ready_q     <= '0;
      grant_q     <= '0;
      time_q      <= '0;
      tvalid_q    <= 1'b0;
      done_q      <= 1'b0;
      steps_q     <= '0;
      terr_q      <= 1'b0;
      oerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      cand_time_q <= cand_time_d;
      cand_mask_q <= cand_mask_d;
      ready_q     <= ready_d;
      grant_q     <= grant_d;
      time_q      <= time_d;
      tvalid_q    <= tvalid_d;
      done_q      <= done_d;
      steps_q     <= steps_d;
      terr_q      <= terr_d;
      oerr_q      <= oerr_d;
    end
  end

  // An abort landing in the ADVANCE cycle must not let a proposal transfer.
  assign req_ready_o   = ready_q & {N{~abort_i}};
  assign step_grant_o  = grant_q;
  assign time_curr_o   = time_q;
  assign time_valid_o  = tvalid_q;
  assign busy_o        = (state_q == ST_COLLECT) || (state_q == ST_ADVANCE);
  assign done_o        = done_q;
  assign steps_done_o  = steps_q;
  assign timeout_err_o = terr_q;
  assign order_err_o   = oerr_q;

endmodule

// File: tb/tb_time_step_scheduler.sv
// Scoreboard bench: expected steps/ready pulses are queued by the stimulus,
// a monitor thread pops and compares them whenever the DUT presents them.
module tb_time_step_scheduler;
  import time_step_scheduler_pkg::*;

  localparam int N  = 4;
  localparam int BB = 16;
  localparam int MW = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [BB-1:0]     budget = '0;
  time_fmt_t         stop_t = '0;
  logic [N-1:0]      req_valid = '0;
  time_fmt_t [N-1:0] req_time = '0;
  logic [N-1:0]      req_ready, step_grant;
  time_fmt_t         time_curr;
  logic              time_valid, busy, done, timeout_err, order_err;
  logic [BB-1:0]     steps_done;

  typedef struct packed {
    time_fmt_t     t;
    logic [N-1:0]  g;
    logic [BB-1:0] s;
  } step_t;

  step_t        exp_step[$];
  logic [N-1:0] exp_rdy[$];
  int unsigned  plist[N][8];
  int           pcnt[N];
  int           pidx[N];
  int           n_cmp = 0;
  int           n_fail = 0;

  time_step_scheduler #(.N(N), .BUDGET_BITS(BB), .MAX_WAIT(MW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .abort_i       (abort),
    .step_budget_i (budget),
    .stop_time_i   (stop_t),
    .req_valid_i   (req_valid),
    .req_time_i    (req_time),
    .req_ready_o   (req_ready),
    .step_grant_o  (step_grant),
    .time_curr_o   (time_curr),
    .time_valid_o  (time_valid),
    .busy_o        (busy),
    .done_o        (done),
    .steps_done_o  (steps_done),
    .timeout_err_o (timeout_err),
    .order_err_o   (order_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic clear_props();
    for (int i = 0; i < N; i++) begin
      pcnt[i] = 0;
      pidx[i] = 0;
    end
    req_valid = '0;
  endtask

  task automatic prop(input int i, input int unsigned v);
    plist[i][pcnt[i]] = v;
    pcnt[i]++;
  endtask

  task automatic present();
    for (int i = 0; i < N; i++) begin
      if (pcnt[i] > 0) begin
        req_time[i]  = plist[i][0];
        pidx[i]      = 1;
        req_valid[i] = 1'b1;
      end
    end
  endtask

  task automatic expect_step(input int unsigned t, input logic [N-1:0] g, input int s);
    step_t e;
    e.t = t;
    e.g = g;
    e.s = BB'(s);
    exp_step.push_back(e);
    exp_rdy.push_back(g);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int k = 0;
    while (busy && k < max) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, 64'(busy), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic wait_rdy(input string name, input int max);
    int k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (req_ready == '0 && k < max);
    chk(name, 64'(req_ready != '0), 64'(1));
  endtask

  initial begin
    fork
      // Requester model: on a consumed proposal, present the next one or drop valid.
      begin : responder
        logic [N-1:0] rdy;
        forever begin
          @(negedge clk);
          rdy = req_ready;
          @(posedge clk); #1;
          for (int i = 0; i < N; i++) begin
            if (rdy[i] && req_valid[i]) begin
              if (pidx[i] < pcnt[i]) begin
                req_time[i] = plist[i][pidx[i]];
                pidx[i]++;
              end else begin
                req_valid[i] = 1'b0;
              end
            end
          end
        end
      end
      // Monitor: compare every time_valid / req_ready against the queues.
      begin : monitor
        step_t        e;
        logic [N-1:0] r;
        forever begin
          @(negedge clk);
          if (time_valid) begin
            if (exp_step.size() == 0) begin
              chk("unexpected time_valid", 64'(time_valid), 64'(0));
            end else begin
              e = exp_step.pop_front();
              chk("time_curr", 64'(time_curr), 64'(e.t));
              chk("step_grant", 64'(step_grant), 64'(e.g));
              chk("steps_done", 64'(steps_done), 64'(e.s));
            end
          end
          if (req_ready != '0) begin
            if (exp_rdy.size() == 0) begin
              chk("unexpected req_ready", 64'(req_ready), 64'(0));
            end else begin
              r = exp_rdy.pop_front();
              chk("req_ready", 64'(req_ready), 64'(r));
            end
          end
        end
      end
      begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst time_curr", 64'(time_curr), 64'(0));
    chk("rst outputs", 64'({req_ready, step_grant, time_valid, busy, done, timeout_err, order_err}), 64'(0));
    chk("rst steps_done", 64'(steps_done), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Budget-limited run from time 0
    clear_props();
    budget = 16'd3;
    stop_t = 1000;
    prop(0, 10); prop(0, 20); prop(0, 30); prop(0, 40);
    prop(1, 20); prop(1, 40); prop(1, 60);
    prop(2, 30); prop(2, 60);
    prop(3, 40); prop(3, 80);
    expect_step(10, 4'b0001, 1);
    expect_step(20, 4'b0011, 2);
    expect_step(30, 4'b0101, 3);
    present();
    pulse_start();
    wait_idle("budget run ends", 40);
    chk("budget done", 64'(done), 64'(1));
    chk("budget steps", 64'(steps_done), 64'(3));
    chk("budget time", 64'(time_curr), 64'(30));
    chk("budget queue drained", 64'(exp_step.size()), 64'(0));

    // Reset asserted during ADVANCE
    clear_props();
    budget = '0;
    prop(0, 60); prop(1, 70); prop(2, 80); prop(3, 90);
    present();
    pulse_start();
    wait_rdy("reset run reaches advance", 10);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun rst time_curr", 64'(time_curr), 64'(0));
    chk("midrun rst outputs", 64'({req_ready, step_grant, time_valid, busy, done, timeout_err, order_err}), 64'(0));
    chk("midrun rst steps", 64'(steps_done), 64'(0));
    clear_props();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after rst idle", 64'({busy, done, timeout_err, order_err}), 64'(0));
    chk("after rst time", 64'(time_curr), 64'(0));

    // Ties, partial grant, zero-length step, stop time
    clear_props();
    budget = '0;
    stop_t = 60;
    prop(0, 50); prop(0, 50); prop(0, 80);
    prop(1, 50); prop(1, 75);
    prop(2, 70);
    prop(3, 90);
    expect_step(50, 4'b0011, 1);
    expect_step(50, 4'b0001, 2);
    expect_step(70, 4'b0100, 3);
    present();
    pulse_start();
    wait_idle("tie run ends", 40);
    chk("tie done", 64'(done), 64'(1));
    chk("tie steps", 64'(steps_done), 64'(3));
    chk("tie time", 64'(time_curr), 64'(70));
    chk("tie queue drained", 64'(exp_step.size()), 64'(0));

    // Timeout: one requester never proposes
    clear_props();
    stop_t = 1000;
    req_time = {4{32'd100}};
    req_valid = 4'b0111;
    pulse_start();
    repeat (14) begin
      @(posedge clk); #1;
    end
    chk("timeout not yet busy", 64'(busy), 64'(1));
    chk("timeout not yet err", 64'(timeout_err), 64'(0));
    @(posedge clk); #1;
    chk("timeout err", 64'(timeout_err), 64'(1));
    chk("timeout busy", 64'(busy), 64'(0));
    pulse_start();
    chk("restart clears timeout", 64'(timeout_err), 64'(0));
    chk("restart busy", 64'(busy), 64'(1));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort from collect", 64'(busy), 64'(0));

    // Move time to 100, then propose a time in the past
    clear_props();
    budget = 16'd1;
    for (int i = 0; i < N; i++) prop(i, 100);
    expect_step(100, 4'b1111, 1);
    present();
    pulse_start();
    wait_idle("to-100 run ends", 20);
    chk("to-100 done", 64'(done), 64'(1));
    chk("to-100 time", 64'(time_curr), 64'(100));
    clear_props();
    budget = '0;
    req_time = {4{32'd80}};
    req_valid = 4'b1111;
    pulse_start();
    wait_idle("order run ends", 20);
    chk("order err", 64'(order_err), 64'(1));
    chk("order time held", 64'(time_curr), 64'(100));
    chk("order no step", 64'({done, timeout_err}), 64'(0));
    chk("order steps", 64'(steps_done), 64'(0));

    // Abort together with start in the ADVANCE cycle
    clear_props();
    for (int i = 0; i < N; i++) prop(i, 200);
    present();
    pulse_start();
    wait_rdy("abort run reaches advance", 10);
    abort = 1'b1;
    start = 1'b1;
    #1;
    chk("abort gates ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    chk("abort to idle", 64'(busy), 64'(0));
    chk("abort no done", 64'(done), 64'(0));
    chk("abort time held", 64'(time_curr), 64'(100));
    chk("abort grant held", 64'(step_grant), 64'(4'b1111));
    @(posedge clk); #1;
    chk("abort no time_valid", 64'(time_valid), 64'(0));
    chk("final ready queue drained", 64'(exp_rdy.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
